// File: rtl/noise_source_if.sv
// noise_source control/sample bundle.
// Master drives enable and seeding; slave returns samples.
interface noise_source_if #(
  parameter int NCH = 4
);
  logic           en;
  logic           seed_load;
  logic [31:0]    seed_in;
  logic [NCH-1:0] nois;
  logic           valid;

  modport master (
    output en, seed_load, seed_in,
    input  nois, valid
  );

  modport slave (
    input  en, seed_load, seed_in,
    output nois, valid
  );
endinterface

// File: rtl/noise_source.sv
// Multi-channel Bernoulli noise source.
// Channel n is high with probability 1/2^n, from a 32-bit LFSR.
module noise_source #(
  parameter int          NCH  = 4,
  parameter int          STEP = 16,
  parameter logic [31:0] SEED = 32'hACE1_2468,
  parameter int          WARM = 8
) (
  input logic           clk,
  input logic           rst_n,
  noise_source_if.slave bus
);

  typedef enum logic {
    S_WARMUP,
    S_RUN
  } state_t;

  localparam int CW = (WARM > 0) ? $clog2(WARM + 1) : 1;
  localparam logic [CW:0] L_WARM = (CW + 1)'(WARM);

  if (NCH < 1 || STEP < 1 || STEP > 32 ||
      NCH * (NCH + 1) / 2 > STEP) begin : g_bad_cfg
    $error("noise_source: NCH/STEP out of range");
  end

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_lfsr;
  logic [NCH-1:0]  r_nois;
  logic            r_valid;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW:0]     w_cnt_inc;
  logic [31:0]     w_lfsr_nxt;
  logic [31:0]     w_step;
  logic [NCH-1:0]  w_map;
  logic [NCH-1:0]  w_nois_nxt;
  logic            w_valid_nxt;

  // Advance the LFSR STEP single-bit shifts in one clock.
  always_comb begin
    logic [31:0] v;
    v = r_lfsr;
    for (int i = 0; i < STEP; i++) begin
      v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    end
    w_step = v;
  end

  // Each channel ANDs its own disjoint run of n bits.
  for (genvar g = 0; g < NCH; g++) begin : g_map
    assign w_map[g] = &r_lfsr[g * (g + 1) / 2 +: g + 1];
  end

  assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;

  // Next state: seed load beats enable; en low freezes everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lfsr_nxt  = r_lfsr;
    w_nois_nxt  = '0;
    w_valid_nxt = 1'b0;
    unique case (1'b1)
      bus.seed_load: begin
        w_lfsr_nxt  = (bus.seed_in == 32'd0) ? SEED
                                             : bus.seed_in;
        w_state_nxt = S_WARMUP;
        w_cnt_nxt   = '0;
      end
      (!bus.seed_load && bus.en &&
       r_state == S_RUN): begin
        w_lfsr_nxt  = w_step;
        w_nois_nxt  = w_map;
        w_valid_nxt = 1'b1;
      end
      (!bus.seed_load && bus.en &&
       r_state == S_WARMUP): begin
        w_lfsr_nxt = w_step;
        w_cnt_nxt  = w_cnt_inc[CW-1:0];
        if (w_cnt_inc >= L_WARM) begin
          w_state_nxt = S_RUN;
        end
      end
      default: ;
    endcase
  end

  // State, LFSR and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WARMUP;
      r_cnt   <= '0;
      r_lfsr  <= SEED;
      r_nois  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_nois  <= w_nois_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign bus.nois  = r_nois;
  assign bus.valid = r_valid;

endmodule

// File: tb/tb_noise_source.sv
// Bench for noise_source: bit-stream reference model,
// statistics, enable gating, seeding and reset.
module tb_noise_source;

  localparam int          NCH  = 4;
  localparam int          STEP = 16;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam int          WARM = 8;

  logic clk = 1'b0;
  logic rst_n;

  noise_source_if #(.NCH(NCH)) bus ();

  noise_source #(
    .NCH (NCH),
    .STEP(STEP),
    .SEED(SEED),
    .WARM(WARM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: bit history, newest bit last; l[i] == mq[$-i].
  bit mq[$];
  int m_warm;
  bit m_run;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag,
                           input int v,
                           input int lo,
                           input int hi);
    n_chk++;
    assert (v >= lo && v <= hi) else begin
      n_err++;
      $error("FAIL %s obs=%0d exp=%0d..%0d",
             tag, v, lo, hi);
    end
  endtask

  task automatic mdl_seed(input logic [31:0] s);
    logic [31:0] v;
    v = (s == 32'd0) ? SEED : s;
    mq.delete();
    for (int i = 31; i >= 0; i--) mq.push_back(v[i]);
    m_warm = 0;
    m_run  = 1'b0;
  endtask

  task automatic mdl_shift();
    bit nb;
    nb = mq[$-31] ^ mq[$-21] ^ mq[$-1] ^ mq[$];
    mq.push_back(nb);
    void'(mq.pop_front());
  endtask

  function automatic logic [NCH-1:0] mdl_map();
    logic [NCH-1:0] r;
    for (int n = 1; n <= NCH; n++) begin
      bit b;
      b = 1'b1;
      for (int j = 0; j < n; j++)
        b = b & mq[$ - (n * (n - 1) / 2 + j)];
      r[n-1] = b;
    end
    return r;
  endfunction

  function automatic logic [31:0] mdl_lfsr();
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = mq[$-i];
    return r;
  endfunction

  // One clock with the currently driven inputs, checked.
  task automatic cyc(input string tag,
                     output logic [NCH:0] got);
    logic [NCH:0] exp;
    exp = '0;
    if (bus.seed_load) begin
      mdl_seed(bus.seed_in);
    end else if (bus.en) begin
      if (m_run) exp = {1'b1, mdl_map()};
      else begin
        m_warm++;
        if (m_warm >= WARM) m_run = 1'b1;
      end
      for (int i = 0; i < STEP; i++) mdl_shift();
    end
    @(posedge clk);
    #1;
    got = {bus.valid, bus.nois};
    check(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NCH:0]   g;
    logic [NCH-1:0] ref_seq[$];
    logic [NCH-1:0] comp[$];
    bit             snap[$];
    int first_valid;
    int c1, c2, c3, c4, c12;
    bit nz;

    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed_in   = 32'd0;
    mdl_seed(SEED);
    #12;
    check("rst_out", 32'({bus.valid, bus.nois}), 32'd0);
    check("rst_lfsr", dut.r_lfsr, SEED);

    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    bus.en = 1'b1;

    first_valid = -1;
    c1 = 0; c2 = 0; c3 = 0; c4 = 0; c12 = 0;
    for (int k = 1; k <= WARM + 65536; k++) begin
      cyc("seq_default", g);
      if (g[NCH] && first_valid < 0) first_valid = k;
      if (k > WARM) begin
        c1  += int'(g[0]);
        c2  += int'(g[1]);
        c3  += int'(g[2]);
        c4  += int'(g[3]);
        c12 += int'(g[0] & g[1]);
        if (k - WARM <= 64) ref_seq.push_back(g[NCH-1:0]);
      end
    end
    check("valid_rise", 32'(first_valid), 32'(WARM + 1));
    check_rng("stat_ch1", c1, 32768 - 700, 32768 + 700);
    check_rng("stat_ch2", c2, 16384 - 550, 16384 + 550);
    check_rng("stat_ch3", c3, 8192 - 400, 8192 + 400);
    check_rng("stat_ch4", c4, 4096 - 300, 4096 + 300);
    check_rng("stat_ch12", c12, 8192 - 400, 8192 + 400);

    nz = 1'b0;
    for (int k = 0; k < 100 && !nz; k++) begin
      cyc("pre_rst", g);
      nz = (g[NCH-1:0] != '0);
    end
    check("nz_before_rst", 32'(nz), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'({bus.valid, bus.nois}), 32'd0);
    check("async_rst_lfsr", dut.r_lfsr, SEED);
    mdl_seed(SEED);
    #1;
    rst_n = 1'b1;

    bus.seed_in   = 32'd0;
    bus.seed_load = 1'b1;
    cyc("zero_load", g);
    bus.seed_load = 1'b0;
    check("zero_seed_lfsr", dut.r_lfsr, SEED);
    for (int k = 1; k <= WARM + 64; k++) begin
      cyc("seq_zero", g);
      if (k > WARM)
        check("zero_eq_reset", 32'(g[NCH-1:0]),
              32'(ref_seq[k - WARM - 1]));
    end

    bus.seed_in   = 32'h0000_0001;
    bus.seed_load = 1'b1;
    cyc("load1", g);
    bus.seed_load = 1'b0;
    check("load_drops_valid", 32'(g[NCH]), 32'd0);
    check("load1_lfsr", dut.r_lfsr, 32'h0000_0001);
    for (int k = 1; k <= WARM + 1000; k++) cyc("seq_seed1", g);

    bus.seed_in   = 32'h1234_5678;
    bus.seed_load = 1'b1;
    cyc("b2b_a", g);
    bus.seed_in   = 32'hDEAD_BEEF;
    cyc("b2b_b", g);
    bus.seed_load = 1'b0;
    check("b2b_last_wins", dut.r_lfsr, 32'hDEAD_BEEF);
    for (int k = 1; k <= WARM + 100; k++) cyc("seq_b2b", g);

    snap = mq;
    for (int c = 0; c < 200; c++) begin
      bus.en = ((c % 8) < 3);
      cyc("gate", g);
      if (g[NCH]) comp.push_back(g[NCH-1:0]);
      else check("gate_zero", 32'(g[NCH-1:0]), 32'd0);
    end
    bus.en = 1'b1;
    check("gate_count", 32'(comp.size()), 32'd75);
    mq = snap;
    foreach (comp[i]) begin
      check("gate_compact", 32'(comp[i]), 32'(mdl_map()));
      for (int s = 0; s < STEP; s++) mdl_shift();
    end
    check("gate_lfsr", dut.r_lfsr, mdl_lfsr());

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/noise_source.md
Name: noise_source

Overview:
- Generates the independent noisy channels consumed by the noise munger.
- Channel n (n = 1..NCH) is 1 with probability 1/2^n.
- Built on a 32-bit Fibonacci LFSR advanced STEP bits per clock; channel n is the AND of n LFSR bits that belong to no other channel.
- Provides seed loading, a warm-up period and an enable, so a bench can reproduce any sequence bit-exactly.

Parameters:
- NCH, 4, number of channels; NCH*(NCH+1)/2 must be ≤ STEP (elaboration error otherwise).
- STEP, 16, LFSR shifts per clock (unrolled); 1..32.
- SEED, 32'hACE1_2468, reset seed and replacement for an all-zero seed.
- WARM, 8, clocks of warm-up (outputs forced 0) after reset or seed load; 0 allowed.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance the generator; low freezes the LFSR.
- seed_load  in  1  one-cycle strobe; loads seed_in.
- seed_in  in  32  seed value.
- nois  out  NCH  nois[n-1] = channel n, P(1) = 1/2^n.
- valid  out  1  high while nois carries live samples (RUN state).

Behaviour:
- Reset (asynchronous, rst_n low):
  - lfsr=SEED, state=WARMUP, warm counter=0, nois=0, valid=0.
  - Reset is honoured mid-operation at any point, with the same values.
- LFSR:
  - Polynomial x^32+x^22+x^2+x+1.
  - One step: new bit = l[31]^l[21]^l[1]^l[0]; shift left; new bit enters l[0].
  - Each clock with en=1 (and no seed_load), lfsr ← lfsr stepped STEP times, combinational unroll.
  - After a clock, bits l[STEP-1:0] are all freshly generated.
- Channel mapping (from the current, pre-update lfsr):
  - Channel n ANDs bits [n(n-1)/2 +: n].
  - NCH=4: ch1=l[0]; ch2=l[1]&l[2]; ch3=&l[5:3]; ch4=&l[9:6].
- Output timing: nois and valid are registered; latency 1.
  - nois at edge t+1 = mapping of lfsr value held between edges t and t+1.
- States:
  - WARMUP: en=1 increments the warm counter; nois=0, valid=0. Counter reaching WARM → RUN. WARM=0 enters RUN on the first en=1 clock. That clock still registers 0; valid rises on the following clock.
  - RUN: en=1 → nois=mapping, valid=1. en=0 → LFSR and state hold, nois=0, valid=0. On en returning to 1, output resumes from the held lfsr value, with no skipped or repeated samples.
- seed_load (takes priority over en, any state):
  - lfsr ← seed_in, or SEED if seed_in==0 (LFSR lock-up avoidance).
  - state ← WARMUP, counter ← 0, nois ← 0, valid ← 0.
  - Back-to-back strobes: the last one wins.
- Any seed except zero produces the full sequence; the generator never reaches lfsr==0.

Test Plan:
- Reset:
  - Assert rst_n=0 mid-RUN with nois≠0 → nois=0 and valid=0 immediately, without a clock.
  - Release with en=1, WARM=8 → valid rises exactly 9 clocks after the first en=1 edge.
- Bit-exact model:
  - SEED default, en=1 for 1000 clocks.
  - Compare nois every cycle against a bench LFSR/mapping model → zero mismatches.
  - Repeat with seed_load seed_in=32'h0000_0001.
- Zero seed: seed_load with seed_in=0 → internal lfsr==SEED; output sequence identical to the post-reset sequence.
- Statistics (65536 RUN samples, default seed):
  - ch1 count 32768±700; ch2 16384±550; ch3 8192±400; ch4 4096±300.
  - Joint ch1&ch2 count 8192±400 (independence check).
- Enable gating:
  - Toggle en in the pattern 3 on / 5 off for 200 clocks.
  - Compact the valid samples → must equal the uninterrupted model sequence.
  - nois=0 whenever valid=0.
- Seed mid-run: seed_load pulse in RUN together with en=1 → valid drops next clock; WARMUP restarts; the sequence after WARM clocks matches the model seeded with seed_in.
